key_event_sequencer: RTL
========================

// Module: key_event_sequencer
// PURPOSE
//  Avalon-MM master that owns the key PIO (edge-capture PIO, regs: 0=data, 2=irq_mask, 3=edge_capture).
//  Writes irq_mask after reset, services the PIO irq by reading and clearing edge_capture,
//  and turns each captured key bit into a queued key-index event for downstream fabric logic.
//  Replaces Nios polling/ISR for key handling; sits between the key PIO slave port and consumer logic.
// PARAMETERS
//  NUM_KEYS    4      number of PIO key bits serviced (1..8); KW = max(1,clog2(NUM_KEYS))
//  KEY_MASK    4'hF   value written to irq_mask at init; also masks captured bits (NUM_KEYS wide)
//  FIFO_DEPTH  8      event FIFO entries, power of 2, >= 2
// PORTS
//  clk             in   1         system clock, same domain as the PIO
//  reset_n         in   1         async active-low reset
//  avm_address     out  2         PIO register address
//  avm_chipselect  out  1         PIO chipselect
//  avm_write_n     out  1         PIO write strobe, active low
//  avm_writedata   out  32        PIO write data
//  avm_readdata    in   32        PIO read data, valid the cycle after the address cycle (fixed latency 1)
//  pio_irq         in   1         PIO irq (|(edge_capture & irq_mask))
//  evt_valid       out  1         event available
//  evt_ready       in   1         consumer accepts event
//  evt_key         out  KW        key index of head event
//  evt_count       out  clog2(FIFO_DEPTH)+1  FIFO occupancy
//  busy            out  1         high in any state except IDLE
// BEHAVIOUR
//  - Reset: state=INIT, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0,
//    FIFO empty (evt_valid=0, evt_count=0, evt_key=0), busy=1, pend=0. Outputs registered.
//  - Reset is async and valid mid-operation: any in-flight read/clear/push is abandoned, FIFO emptied,
//    init write is reissued on first cycle after release.
//  - FSM (one bus op per cycle, no waitrequest):
//    INIT : cs=1, write_n=0, addr=2, wdata={0,KEY_MASK}; 1 cycle -> IDLE.
//    IDLE : cs=0, write_n=1; if pio_irq=1 -> RD, else stay.
//    RD   : cs=1, write_n=1, addr=3; 1 cycle -> CLR.
//    CLR  : pend <= avm_readdata[NUM_KEYS-1:0] & KEY_MASK; same cycle cs=1, write_n=0, addr=3,
//           wdata=32'hFFFF_FFFF (clears edge_capture); next -> PUSH if masked capture !=0, else IDLE.
//    PUSH : select lowest set bit i of pend; if FIFO can accept, push i and clear pend[i];
//           when pend becomes 0 -> IDLE. cs=0 throughout.
//  - pio_irq falls the cycle after CLR; IDLE never re-enters RD on a stale irq.
//  - Edges landing on the PIO between the RD address cycle and the CLR write are lost (PIO
//    clear-all semantics); accepted limitation, window = 1 cycle.
//  - FIFO full in PUSH: stall (no push, pend held, busy=1); no event dropped inside block. Further
//    key edges coalesce in PIO edge_capture and are serviced after return to IDLE.
//  - FIFO: "can accept" = not full OR pop this cycle. Pop when evt_valid & evt_ready.
//    Push into empty FIFO -> evt_valid=1 next cycle, evt_key = pushed index. Simultaneous
//    push+pop: count unchanged. Pointers wrap mod FIFO_DEPTH. evt_key/evt_valid stable while !evt_ready.
//  - Latency: irq high in IDLE at edge E -> RD cycle E+1, CLR E+2, first push E+3,
//    evt_valid E+4 (empty FIFO). k set bits need k PUSH cycles absent stall.
//  - evt_count = occupancy, 0..FIFO_DEPTH.
// TESTING
//  1. Release reset -> exactly one write: addr=2, wdata=0x0000000F; then idle, cs=0, busy=0.
//  2. PIO key2 press (edge_capture=4'b0100, irq=1) -> RD addr=3, clear write wdata=FFFFFFFF,
//     evt_valid 4 cycles after irq sampled, evt_key=2, irq low after clear.
//  3. Keys 0 and 3 same cycle (capture=4'b1001), evt_ready=1 -> events 0 then 3 on consecutive
//     cycles, evt_count peaks 1..2, returns IDLE.
//  4. evt_ready=0, 9 single-key events -> evt_count=8, 9th held in PUSH with busy=1; one pop ->
//     9th pushed same cycle, count stays 8; order preserved.
//  5. KEY_MASK=4'b0111, readdata=4'b1000 from forced irq -> clear write issued, no event, IDLE.
//  6. Assert reset_n during PUSH with 3 events queued -> evt_valid=0, count=0 immediately;
//     after release INIT write reissued, pending bits not pushed.

Source files
------------

// File: rtl/key_event_sequencer.sv
// Avalon-MM master for the key edge-capture PIO: programs irq_mask, services the irq by
// read-then-clear of edge_capture, and queues one key-index event per captured bit.
module key_event_sequencer #(
  parameter int unsigned          NUM_KEYS   = 4,
  parameter logic [NUM_KEYS-1:0]  KEY_MASK   = 4'hF,
  parameter int unsigned          FIFO_DEPTH = 8,
  localparam int unsigned         KW         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int unsigned         CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [1:0]    avm_address,
  output logic          avm_chipselect,
  output logic          avm_write_n,
  output logic [31:0]   avm_writedata,
  input  logic [31:0]   avm_readdata,
  input  logic          pio_irq,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [KW-1:0] evt_key,
  output logic [CW-1:0] evt_count,
  output logic          busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {INIT, IDLE, RD, CLR, PUSH} state_e;

  state_e               state_q, state_d;
  logic [NUM_KEYS-1:0]  pend_q, pend_d;
  logic                 cs_q, cs_d;
  logic                 wn_q, wn_d;
  logic [1:0]           addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 busy_q, busy_d;

  logic [KW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 valid_q, valid_d;

  logic                 push, pop, can_accept;
  logic [KW-1:0]        sel;
  logic [NUM_KEYS-1:0]  cap;
  logic                 unused_rdata;

  assign cap          = avm_readdata[NUM_KEYS-1:0] & KEY_MASK;
  assign unused_rdata = ^avm_readdata;
  assign pop          = valid_q & evt_ready;
  assign can_accept   = (count_q != CW'(FIFO_DEPTH)) | pop;

  // Lowest set pending bit wins.
  always_comb begin
    sel = '0;
    for (int unsigned i = NUM_KEYS; i > 0; i--) begin
      if (pend_q[i-1]) sel = KW'(i - 1);
    end
  end

  // Bus registers load the operation of the state being entered, so the INIT write
  // is presented in the first cycle after reset release.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    push    = 1'b0;
    case (state_q)
      INIT: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = 2'd2;
        wdata_d = {{(32-NUM_KEYS){1'b0}}, KEY_MASK};
        state_d = IDLE;
      end
      IDLE: begin
        if (pio_irq) begin
          cs_d    = 1'b1;
          addr_d  = 2'd3;
          state_d = RD;
        end
      end
      RD: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = 2'd3;
        wdata_d = '1;
        state_d = CLR;
      end
      CLR: begin
        pend_d  = cap;
        state_d = (cap != '0) ? PUSH : IDLE;
      end
      PUSH: begin
        if (can_accept && (pend_q != '0)) begin
          push        = 1'b1;
          pend_d[sel] = 1'b0;
        end
        if (pend_d == '0) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= INIT;
      pend_q   <= '0;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cs_q     <= cs_d;
      wn_q     <= wn_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      if (push) mem_q[wr_ptr_q] <= sel;
    end
  end

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = wdata_q;
  assign evt_valid      = valid_q;
  assign evt_key        = mem_q[rd_ptr_q];
  assign evt_count      = count_q;
  assign busy           = busy_q;

endmodule
